// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller with a 2-entry fetch buffer.
//
// Walks a program counter over a combinational instruction ROM and queues
// {pc, instr} pairs in a two-deep FIFO that the decode stage drains with a
// valid/ready handshake. A redirect (taken branch/jump) re-steers the PC,
// flushes the buffer and spends one bubble cycle in REDIR before fetching
// resumes at the target.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   n_reset      synchronous active-low reset
//   run          fetch enable
//   im_addr      instruction ROM address (current PC)
//   im_data      ROM read data for im_addr, same cycle
//   redirect     re-steer request, highest priority
//   redirect_pc  re-steer target, sampled when redirect=1
//   out_valid    head entry of the fetch buffer is valid
//   out_ready    decode accepts the head entry
//   out_instr    instruction of the head entry
//   out_pc       address of the head entry
//   busy         FSM not idle or buffer non-empty

`ifndef PC_SIZE
`define PC_SIZE 8
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 16
`endif

module fetch_ctrl #(
    parameter int PC_W = `PC_SIZE,
    parameter int IW   = `INSTR_SIZE
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            run,
    output logic [PC_W-1:0] im_addr,
    input  logic [IW-1:0]   im_data,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IW-1:0]   out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam int DEPTH = 2;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [1:0]      count_reg, count_next;

    // Entry 0 is always the head; entry 1 is only meaningful when count=2.
    logic [PC_W-1:0] ent_pc_reg    [DEPTH];
    logic [PC_W-1:0] ent_pc_next   [DEPTH];
    logic [IW-1:0]   ent_instr_reg [DEPTH];
    logic [IW-1:0]   ent_instr_next[DEPTH];

    logic pop;
    logic push;

    assign pop  = (count_reg != 2'd0) & out_ready;
    // A full buffer can still accept a push when the head leaves this cycle.
    assign push = (state_reg == FETCH) & run & ~redirect &
                  ((count_reg != 2'd2) | pop);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic (redirect overrides everything)
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (redirect) begin
            state_next = REDIR;
        end else begin
            case (state_reg)
                IDLE:    state_next = run ? FETCH : IDLE;
                FETCH:   state_next = run ? FETCH : IDLE;
                REDIR:   state_next = run ? FETCH : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        im_addr   = pc_reg;
        out_valid = (count_reg != 2'd0);
        busy      = (state_reg != IDLE) | (count_reg != 2'd0);
        out_pc    = ent_pc_reg[0];
        out_instr = ent_instr_reg[0];
    end

    // ---------------------------------------------------------------
    // PC and FIFO next-state
    // ---------------------------------------------------------------
    always_comb begin
        pc_next    = pc_reg;
        count_next = count_reg;
        for (int i = 0; i < DEPTH; i++) begin
            ent_pc_next[i]    = ent_pc_reg[i];
            ent_instr_next[i] = ent_instr_reg[i];
        end

        if (redirect) begin
            // Flush only resets the count; stale storage is never presented
            // because out_valid follows the count.
            pc_next    = redirect_pc;
            count_next = 2'd0;
        end else begin
            if (push) begin
                pc_next = pc_reg + PC_W'(1);
            end

            if (push && pop) begin
                if (count_reg == 2'd2) begin
                    ent_pc_next[0]    = ent_pc_reg[1];
                    ent_instr_next[0] = ent_instr_reg[1];
                    ent_pc_next[1]    = pc_reg;
                    ent_instr_next[1] = im_data;
                end else begin
                    ent_pc_next[0]    = pc_reg;
                    ent_instr_next[0] = im_data;
                end
            end else if (push) begin
                if (count_reg == 2'd0) begin
                    ent_pc_next[0]    = pc_reg;
                    ent_instr_next[0] = im_data;
                end else begin
                    ent_pc_next[1]    = pc_reg;
                    ent_instr_next[1] = im_data;
                end
                count_next = count_reg + 2'd1;
            end else if (pop) begin
                ent_pc_next[0]    = ent_pc_reg[1];
                ent_instr_next[0] = ent_instr_reg[1];
                count_next        = count_reg - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            pc_reg    <= '0;
            count_reg <= 2'd0;
        end else begin
            pc_reg    <= pc_next;
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!n_reset) begin
                    ent_pc_reg[gi]    <= '0;
                    ent_instr_reg[gi] <= '0;
                end else begin
                    ent_pc_reg[gi]    <= ent_pc_next[gi];
                    ent_instr_reg[gi] <= ent_instr_next[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int PC_W = 8;
    localparam int IW   = 16;

    logic            clk = 1'b0;
    logic            n_reset;
    logic            run;
    logic [PC_W-1:0] im_addr;
    logic [IW-1:0]   im_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [IW-1:0]   out_instr;
    logic [PC_W-1:0] out_pc;
    logic            busy;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // ROM model: ROM[i] = i + 0x100
    assign im_data = 16'h0100 + {8'h00, im_addr};

    fetch_ctrl #(.PC_W(PC_W), .IW(IW)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .run        (run),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s: got %0h", tag, obs);
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check a presented head entry: valid, pc and ROM-derived instruction.
    task automatic chk_head(input string tag, input logic [PC_W-1:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"},    32'(out_pc),    32'(pc));
        chk({tag, "_instr"}, 32'(out_instr), 32'h100 + 32'(pc));
    endtask

    initial begin
        n_reset     = 1'b0;
        run         = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_addr",  32'(im_addr),   32'd0);
        chk("rst_pc",    32'(out_pc),    32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);

        // Streaming from reset release
        n_reset   = 1'b1;
        run       = 1'b1;
        out_ready = 1'b1;
        tick();                                   // IDLE -> FETCH
        chk("c1_valid", 32'(out_valid), 32'd0);
        chk("c1_addr",  32'(im_addr),   32'd0);
        tick();
        chk_head("c2", 8'h00);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_head("stream", 8'(k));
        end

        // Back-pressure: buffer fills to 2, PC stalls, head held
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_head("stall", 8'h05);
        end
        chk("stall_addr", 32'(im_addr), 32'h07);
        out_ready = 1'b1;
        tick();
        chk_head("resume6", 8'h06);
        tick();
        chk_head("resume7", 8'h07);
        tick();
        chk_head("resume8", 8'h08);

        // Redirect while full
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        chk("rd1_valid", 32'(out_valid), 32'd0);
        chk("rd1_addr",  32'(im_addr),   32'h20);
        chk("rd1_busy",  32'(busy),      32'd1);
        tick();
        chk("rd2_valid", 32'(out_valid), 32'd0);
        tick();
        chk_head("rd20", 8'h20);
        tick();
        chk_head("rd21", 8'h21);

        // Redirect to the top address: PC wraps to zero
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        tick();
        chk("wr_valid", 32'(out_valid), 32'd0);
        tick();
        chk_head("wrFF", 8'hFF);
        tick();
        chk_head("wr00", 8'h00);

        // Fill to 2, drop run, drain
        out_ready = 1'b0;
        tick();
        tick();
        chk("fill_addr", 32'(im_addr), 32'h02);
        run       = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_head("drain1", 8'h01);
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_busy",  32'(busy),      32'd0);
        chk("drain_addr",  32'(im_addr),   32'h02);
        tick();
        chk("hold_addr", 32'(im_addr), 32'h02);

        // Stream at 0x10, then reset mid-operation
        run         = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk_head("pre_rst", 8'h10);
        n_reset = 1'b0;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_addr",  32'(im_addr),   32'd0);
        chk("mrst_busy",  32'(busy),      32'd0);
        chk("mrst_pc",    32'(out_pc),    32'd0);
        n_reset = 1'b1;
        tick();
        chk("rs1_valid", 32'(out_valid), 32'd0);
        tick();
        chk_head("rs0", 8'h00);
        tick();
        chk_head("rs1", 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
